h2c_checker: RTL
================

# h2c_checker

H2C stream sink and checker, the receive-side counterpart of the C2H traffic generator path. It accepts the QDMA H2C AXI-Stream and applies controllable backpressure. It checks every packet against the generator's sequence/index payload pattern, its expected byte length and its tkeep rules. It keeps packet, byte and error counters for the user register block and flags completion after a programmed packet count.

## Interface
- C_DATA_WIDTH, 512, stream data width in bits; multiple of 32.
- MAX_ETH_FRAME, 2048, largest legal packet in bytes; sizes the per-packet byte accumulator.

- axi_aclk  in  1  the block's only clock.
- axi_areset  in  1  reset; synchronous, active-high.
- control_reg  in  32  control bits:
  - [1] start: run while high.
  - [2] clear: zero the counters and err_flag; honoured only in IDLE.
  - [7:4] throttle N.
  - all other bits ignored.
- exp_pkt_len  in  16  expected packet length in bytes, 1..MAX_ETH_FRAME.
- num_pkt  in  11  packets to receive before DONE; 0 means unlimited.
- h2c_tdata  in  C_DATA_WIDTH  payload.
- h2c_tkeep  in  C_DATA_WIDTH/8  byte enables; bit i qualifies byte i.
- h2c_tvalid  in  1  beat valid.
- h2c_tlast  in  1  last beat of the packet.
- h2c_tready  out  1  sink ready.
- pkt_count  out  32  packets completed, good or bad.
- byte_count  out  32  bytes accepted (sum of set tkeep bits).
- err_count  out  16  packets with at least one error; saturates at 0xFFFF.
- err_flag  out  1  sticky; set on the first bad packet.
- done  out  1  high while in DONE.

## Operation
- State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN: start=1 and clear=0. Packet sequence and beat index are reset to 0 on this transition.
  - RUN → DONE: on the tlast handshake that makes pkt_count equal num_pkt (num_pkt≠0).
  - RUN → DRAIN: start falls while a packet is open (a beat was accepted with no tlast yet).
  - RUN → IDLE: start falls with no packet open.
  - DRAIN → IDLE: on the tlast handshake.
  - DONE → IDLE: start=0.
- h2c_tready:
  - 0 in IDLE and DONE.
  - In RUN and DRAIN: 1, except that when N≠0 a free-running modulo-(N+1) counter forces it to 0 for one cycle in every N+1.
  - Never depends on h2c_tvalid.
- Expected payload: 32-bit lane k of beat b in packet p equals {p[15:0], (b*(C_DATA_WIDTH/32)+k)[15:0]}. p counts packets since leaving IDLE; b is the beat index within the packet.
- Per-beat checks, on handshake:
  - Data error: any byte with tkeep=1 differs from the expected byte. Bytes with tkeep=0 are ignored.
  - Keep error, non-last beat: tkeep is not all ones.
  - Keep error, last beat: tkeep is zero or not contiguous from bit 0.
- Per-packet checks, at tlast:
  - Length error: accumulated byte count ≠ exp_pkt_len.
  - The accumulator saturates at MAX_ETH_FRAME+1, so overlength packets always flag.
- A packet with any error increments err_count once and sets err_flag. pkt_count increments for every packet.
- byte_count adds popcount(tkeep) per accepted beat. It wraps modulo 2^32.
- Clear in IDLE zeroes pkt_count, byte_count, err_count and err_flag on the next edge.
- Reset mid-packet: all state returns to reset values immediately and the partial packet is discarded uncounted. The upstream source must restart at a packet boundary.

## Timing
- Reset values:
  - h2c_tready=0, done=0, err_flag=0.
  - All counters 0; state IDLE.
- Pipeline: stage 1 registers the beat together with its compare and keep results. Stage 2 accumulates and updates the counters.
- byte_count reflects a beat 2 cycles after its handshake. pkt_count, err_count and err_flag reflect a tlast beat 2 cycles after its handshake.
- State transitions take effect on the edge after the causing handshake or control change. done rises 1 cycle after the final tlast handshake; counters become final 1 cycle later.
- Sustained throughput: 1 beat/cycle with N=0 and N/(N+1) otherwise.
- A tlast on the same cycle that start falls completes the packet and goes to IDLE, not DRAIN.

## Test plan
- Run with num_pkt=4, exp_pkt_len=256 and clean pattern packets of 4 full 64-byte beats, N=0. Required: pkt_count=4, byte_count=1024, err_count=0; done=1; tready=0 afterwards.
- Send one packet with exp_pkt_len=100: beat 0 with full tkeep, beat 1 with tkeep=0x0000_000F_FFFF_FFFF. Required: byte_count=100 and no errors. Then flip one byte in a tkeep=0 region: still no errors.
- Corrupt lane 3 of packet 2. Required: err_count=1, err_flag=1, pkt_count=3 after 3 packets.
- Send a last beat with tkeep=0x...F0F (non-contiguous), then a packet one beat longer than exp_pkt_len. Required: err_count=2.
- Set N=3 and hold tvalid high. Required: tready low on exactly 1 cycle in every 4; all beats are accepted intact.
- Drop start mid-packet. Required: the remaining beats are accepted, the state reaches IDLE after tlast, pkt_count increments by 1. Separately, assert reset mid-packet: counters are 0 and tready=0 on the next cycle.

Source files
------------

// File: rtl/h2c_checker.sv
// h2c_checker: H2C stream sink that checks the generator payload pattern, keep rules and length, and counts packets/bytes/errors.
module h2c_checker #(
   parameter int C_DATA_WIDTH  = 512,
   parameter int MAX_ETH_FRAME = 2048
) (
   input  logic                      axi_aclk,
   input  logic                      axi_areset,
   input  logic [31:0]               control_reg,
   input  logic [15:0]               exp_pkt_len,
   input  logic [10:0]               num_pkt,
   input  logic [C_DATA_WIDTH-1:0]   h2c_tdata,
   input  logic [C_DATA_WIDTH/8-1:0] h2c_tkeep,
   input  logic                      h2c_tvalid,
   input  logic                      h2c_tlast,
   output logic                      h2c_tready,
   output logic [31:0]               pkt_count,
   output logic [31:0]               byte_count,
   output logic [15:0]               err_count,
   output logic                      err_flag,
   output logic                      done
);
   localparam int KW    = C_DATA_WIDTH / 8;
   localparam int LANES = C_DATA_WIDTH / 32;
   localparam int CW    = $clog2(KW + 1);
   localparam int AW    = $clog2(MAX_ETH_FRAME + 2);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic start, clear, clr, hs, open_nxt, pkt_open, data_err, keep_err, len_err, pkt_bad;
   logic [3:0] thr, thr_cnt;
   logic [15:0] seq, beat;
   logic [31:0] pkt_tot;
   logic [C_DATA_WIDTH-1:0] exp_data;
   logic [CW-1:0] nbytes, s1_bytes;
   logic s1_valid, s1_last, s1_err, pkt_err;
   logic [AW-1:0] acc, acc_sat;
   logic [AW:0] acc_sum;
   assign start      = control_reg[1];
   assign clear      = control_reg[2];
   assign thr        = control_reg[7:4];
   assign clr        = state == IDLE && clear;
   assign h2c_tready = (state == RUN || state == DRAIN) && !(thr != 4'd0 && thr_cnt == thr);
   assign hs         = h2c_tvalid && h2c_tready;
   assign open_nxt   = hs ? !h2c_tlast : pkt_open;
   assign done       = state == DONE;
   genvar k;
   for (k = 0; k < LANES; k++) begin : g_lane
      assign exp_data[32*k +: 32] = {seq, 16'(beat * 16'(LANES) + 16'(k))};
   end
   always_comb begin
      data_err = 1'b0;
      nbytes   = '0;
      for (int i = 0; i < KW; i++) begin
         data_err = data_err | (h2c_tkeep[i] && h2c_tdata[8*i +: 8] != exp_data[8*i +: 8]);
         nbytes   = nbytes + CW'(h2c_tkeep[i]);
      end
      keep_err = h2c_tlast ? (h2c_tkeep == '0 || (h2c_tkeep & (h2c_tkeep + KW'(1))) != '0)
                           : !(&h2c_tkeep);
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !clear) state_nxt = RUN;
         RUN:     if (hs && h2c_tlast && num_pkt != 11'd0 && pkt_tot + 32'd1 == 32'(num_pkt)) state_nxt = DONE;
                  else if (!start) state_nxt = open_nxt ? DRAIN : IDLE;
         DRAIN:   if (hs && h2c_tlast) state_nxt = IDLE;
         default: if (!start) state_nxt = IDLE;
      endcase
   end
   // accumulator saturates one past the largest frame so overlength never aliases a legal length
   always_comb begin
      acc_sum = {1'b0, acc} + (AW+1)'(s1_bytes);
      acc_sat = acc_sum > (AW+1)'(MAX_ETH_FRAME + 1) ? AW'(MAX_ETH_FRAME + 1) : acc_sum[AW-1:0];
      len_err = 16'(acc_sat) != exp_pkt_len;
      pkt_bad = pkt_err || s1_err || len_err;
   end
   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state      <= IDLE;
         thr_cnt    <= '0;
         seq        <= '0;
         beat       <= '0;
         pkt_open   <= 1'b0;
         pkt_tot    <= '0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_err     <= 1'b0;
         s1_bytes   <= '0;
         acc        <= '0;
         pkt_err    <= 1'b0;
         pkt_count  <= '0;
         byte_count <= '0;
         err_count  <= '0;
         err_flag   <= 1'b0;
      end else begin
         state    <= state_nxt;
         thr_cnt  <= thr_cnt >= thr ? 4'd0 : thr_cnt + 4'd1;
         seq      <= state == IDLE ? 16'd0 : (hs && h2c_tlast ? seq + 16'd1 : seq);
         beat     <= state == IDLE ? 16'd0 : (hs ? (h2c_tlast ? 16'd0 : beat + 16'd1) : beat);
         pkt_open <= state != IDLE && open_nxt;
         pkt_tot  <= clr ? 32'd0 : (hs && h2c_tlast ? pkt_tot + 32'd1 : pkt_tot);
         s1_valid <= hs;
         s1_last  <= hs && h2c_tlast;
         s1_err   <= data_err || keep_err;
         s1_bytes <= nbytes;
         if (clr) begin
            acc        <= '0;
            pkt_err    <= 1'b0;
            pkt_count  <= '0;
            byte_count <= '0;
            err_count  <= '0;
            err_flag   <= 1'b0;
         end else if (s1_valid) begin
            byte_count <= byte_count + 32'(s1_bytes);
            acc        <= s1_last ? '0 : acc_sat;
            pkt_err    <= !s1_last && (pkt_err || s1_err);
            if (s1_last) begin
               pkt_count <= pkt_count + 32'd1;
               err_count <= pkt_bad && err_count != 16'hFFFF ? err_count + 16'd1 : err_count;
               err_flag  <= err_flag || pkt_bad;
            end
         end
      end
   end
endmodule
